// File: rtl/mestpro_prog_sequencer.sv
// mestpro_prog_sequencer
//
// Program sequencer for the MestPro_V2 core. It holds a small program of
// {instruction, operand} byte pairs. On START it streams the pairs onto the
// core's INSTRUCTION / IN_DATA inputs, one pair per clock. It can run once
// or loop. When no program is running it drives NOP_CODE / 8'h00.
//
// Parameters:
//   DEPTH     number of program words (power of two)
//   ADDR_W    log2(DEPTH)
//   NOP_CODE  instruction driven when no word is being presented
//
// Ports:
//   CLK          single clock, rising edge
//   RESET        synchronous active-high reset; also clears program memory
//   LOAD_EN      program write strobe (dropped while running)
//   LOAD_ADDR    program write address
//   LOAD_INSTR   instruction byte to store
//   LOAD_DATA    operand byte to store
//   START        begin a run from address 0 (ignored while running)
//   STOP         abort a run; takes priority over START in every state
//   LAST_ADDR    address of the final word, latched at START
//   LOOP         restart from address 0 after LAST_ADDR, latched at START
//   INSTRUCTION  registered instruction to the core
//   IN_DATA      registered operand to the core
//   PC           address of the word currently presented
//   BUSY         high while a run is in progress
//   DONE         high after a non-looping run completes
//   ISSUED       words presented since the last START (8-bit wrap)

module mestpro_prog_sequencer #(
    parameter int           DEPTH    = 16,
    parameter int           ADDR_W   = 4,
    parameter logic [7:0]   NOP_CODE = 8'h00
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              LOAD_EN,
    input  logic [ADDR_W-1:0] LOAD_ADDR,
    input  logic [7:0]        LOAD_INSTR,
    input  logic [7:0]        LOAD_DATA,
    input  logic              START,
    input  logic              STOP,
    input  logic [ADDR_W-1:0] LAST_ADDR,
    input  logic              LOOP,
    output logic [7:0]        INSTRUCTION,
    output logic [7:0]        IN_DATA,
    output logic [ADDR_W-1:0] PC,
    output logic              BUSY,
    output logic              DONE,
    output logic [7:0]        ISSUED
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [7:0]          instr_q, instr_d;
    logic [7:0]          data_q, data_d;
    logic [7:0]          issued_q, issued_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic                loop_q, loop_d;

    logic [7:0]          mem_instr [DEPTH];
    logic [7:0]          mem_data  [DEPTH];

    logic                start_run;
    logic                at_last;
    logic [ADDR_W-1:0]   pc_inc;
    logic                mem_we;

    // A run starts from IDLE or DONE only, and only if STOP is low.
    assign start_run = (state_q != S_RUN) && START && !STOP;
    assign at_last   = (pc_q == last_q);
    assign pc_inc    = pc_q + 1'b1;
    assign mem_we    = LOAD_EN && (state_q != S_RUN);

    // ------------------------------------------------------------------
    // State register (together with the registered datapath outputs)
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples the values from before the edge. This keeps
    // simulation order-independent and matches the synthesized flops.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            instr_q  <= NOP_CODE;
            data_q   <= 8'h00;
            issued_q <= 8'h00;
            last_q   <= '0;
            loop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            data_q   <= data_d;
            issued_q <= issued_d;
            last_q   <= last_d;
            loop_q   <= loop_d;
        end
    end

    // Program memory. The read side is combinational from the array, so a
    // START on the same edge as a write presents the old word 0. The new
    // word is committed on that edge and is visible to the next START.
    // NOTE: this memory has a reset because RESET must clear it to NOP.
    // The reset forces flop storage instead of a RAM macro. At 16 words
    // that cost is acceptable.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= NOP_CODE;
                mem_data[i]  <= 8'h00;
            end
        end else if (mem_we) begin
            mem_instr[LOAD_ADDR] <= LOAD_INSTR;
            mem_data[LOAD_ADDR]  <= LOAD_DATA;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default at the top of the
    // block. Then no path can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (STOP)       state_d = S_IDLE;
                else if (START) state_d = S_RUN;
            end
            S_RUN: begin
                if (STOP)                    state_d = S_IDLE;
                else if (at_last && !loop_q) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered core-facing outputs
    // ------------------------------------------------------------------
    always_comb begin
        pc_d     = pc_q;
        instr_d  = NOP_CODE;
        data_d   = 8'h00;
        issued_d = issued_q;
        last_d   = last_q;
        loop_d   = loop_q;

        if (start_run) begin
            // Word 0 goes out on the START edge and counts as the first issue.
            pc_d     = '0;
            instr_d  = mem_instr[0];
            data_d   = mem_data[0];
            issued_d = 8'd1;
            last_d   = LAST_ADDR;
            loop_d   = LOOP;
        end else if (state_q == S_RUN && !STOP) begin
            if (at_last) begin
                if (loop_q) begin
                    pc_d     = '0;
                    instr_d  = mem_instr[0];
                    data_d   = mem_data[0];
                    issued_d = issued_q + 8'd1;
                end
                // Non-looping end: PC holds the last address into DONE.
            end else begin
                pc_d     = pc_inc;
                instr_d  = mem_instr[pc_inc];
                data_d   = mem_data[pc_inc];
                issued_d = issued_q + 8'd1;
            end
        end else if (state_d == S_IDLE) begin
            // IDLE always shows PC 0, including after a STOP.
            pc_d = '0;
        end
    end

    assign INSTRUCTION = instr_q;
    assign IN_DATA     = data_q;
    assign PC          = pc_q;
    assign BUSY        = (state_q == S_RUN);
    assign DONE        = (state_q == S_DONE);
    assign ISSUED      = issued_q;

endmodule

// File: tb/tb_mestpro_prog_sequencer.sv
// Directed testbench for mestpro_prog_sequencer. The expected output
// snapshot for each clock is queued when that cycle's stimulus is driven.
// It is popped and compared one time unit after the rising edge.

module tb_mestpro_prog_sequencer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       LOAD_EN;
    logic [3:0] LOAD_ADDR;
    logic [7:0] LOAD_INSTR;
    logic [7:0] LOAD_DATA;
    logic       START;
    logic       STOP;
    logic [3:0] LAST_ADDR;
    logic       LOOP;
    logic [7:0] INSTRUCTION;
    logic [7:0] IN_DATA;
    logic [3:0] PC;
    logic       BUSY;
    logic       DONE;
    logic [7:0] ISSUED;

    always #5 CLK = ~CLK;

    mestpro_prog_sequencer #(
        .DEPTH    (16),
        .ADDR_W   (4),
        .NOP_CODE (8'h00)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .LOAD_EN     (LOAD_EN),
        .LOAD_ADDR   (LOAD_ADDR),
        .LOAD_INSTR  (LOAD_INSTR),
        .LOAD_DATA   (LOAD_DATA),
        .START       (START),
        .STOP        (STOP),
        .LAST_ADDR   (LAST_ADDR),
        .LOOP        (LOOP),
        .INSTRUCTION (INSTRUCTION),
        .IN_DATA     (IN_DATA),
        .PC          (PC),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .ISSUED      (ISSUED)
    );

    typedef struct packed {
        logic [7:0] instr;
        logic [7:0] data;
        logic [3:0] pc;
        logic       busy;
        logic       done;
        logic [7:0] issued;
    } obs_t;

    obs_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;

    // Reference program contents as the bench expects them to be.
    logic [7:0] ref_instr [16];
    logic [7:0] ref_data  [16];

    function automatic obs_t mk(input logic [7:0] i, input logic [7:0] d,
                                input logic [3:0] p, input logic b,
                                input logic dn, input logic [7:0] n);
        obs_t o;
        o.instr  = i;
        o.data   = d;
        o.pc     = p;
        o.busy   = b;
        o.done   = dn;
        o.issued = n;
        return o;
    endfunction

    task automatic expect_next(input obs_t e);
        exp_q.push_back(e);
    endtask

    // Advance one clock, then compare the DUT outputs with the oldest expectation.
    task automatic tick(input string tag);
        obs_t e;
        obs_t a;
        @(posedge CLK);
        #1;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: no expected value queued", tag);
        end else begin
            e = exp_q.pop_front();
            a = mk(INSTRUCTION, IN_DATA, PC, BUSY, DONE, ISSUED);
            assert (a === e) else begin
                bad++;
                $error("FAIL %s: observed instr=%h data=%h pc=%0d busy=%b done=%b issued=%0d expected instr=%h data=%h pc=%0d busy=%b done=%b issued=%0d",
                       tag, a.instr, a.data, a.pc, a.busy, a.done, a.issued,
                       e.instr, e.data, e.pc, e.busy, e.done, e.issued);
            end
        end
    endtask

    // Pulse START and check n presented words. After the first edge, LAST_ADDR
    // and LOOP are scrambled to show they were latched.
    task automatic run_prog(input logic [3:0] last, input logic lp, input int n,
                            input string tag);
        int w;
        START     = 1'b1;
        LAST_ADDR = last;
        LOOP      = lp;
        for (int i = 0; i < n; i++) begin
            w = lp ? (i % (int'(last) + 1)) : i;
            expect_next(mk(ref_instr[w], ref_data[w], 4'(w), 1'b1, 1'b0, 8'((i + 1) % 256)));
            tick(tag);
            START     = 1'b0;
            LOAD_EN   = 1'b0;
            LAST_ADDR = ~last;
            LOOP      = ~lp;
        end
    endtask

    task automatic load_word(input logic [3:0] a, input logic [7:0] i, input logic [7:0] d,
                             input obs_t idle_exp);
        LOAD_EN    = 1'b1;
        LOAD_ADDR  = a;
        LOAD_INSTR = i;
        LOAD_DATA  = d;
        ref_instr[a] = i;
        ref_data[a]  = d;
        expect_next(idle_exp);
        tick("load");
        LOAD_EN = 1'b0;
    endtask

    initial begin
        RESET      = 1'b1;
        LOAD_EN    = 1'b0;
        LOAD_ADDR  = '0;
        LOAD_INSTR = '0;
        LOAD_DATA  = '0;
        START      = 1'b0;
        STOP       = 1'b0;
        LAST_ADDR  = '0;
        LOOP       = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ref_instr[i] = 8'h00;
            ref_data[i]  = 8'h00;
        end

        // Reset for two cycles, then idle.
        expect_next(mk(8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 8'd0));
        tick("reset0");
        expect_next(mk(8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 8'd0));
        tick("reset1");
        RESET = 1'b0;

        // Load a four-word program.
        load_word(4'd0, 8'h11, 8'hA0, mk(8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 8'd0));
        load_word(4'd1, 8'h22, 8'hA1, mk(8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 8'd0));
        load_word(4'd2, 8'h33, 8'hA2, mk(8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 8'd0));
        load_word(4'd3, 8'h44, 8'hA3, mk(8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 8'd0));

        // Single pass, then DONE, which holds.
        run_prog(4'd3, 1'b0, 4, "run_once");
        expect_next(mk(8'h00, 8'h00, 4'd3, 1'b0, 1'b1, 8'd4));
        tick("done_enter");
        expect_next(mk(8'h00, 8'h00, 4'd3, 1'b0, 1'b1, 8'd4));
        tick("done_hold");

        // Looping run of ten words, then STOP.
        run_prog(4'd3, 1'b1, 10, "run_loop");
        STOP = 1'b1;
        expect_next(mk(8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 8'd10));
        tick("stop_loop");
        STOP = 1'b0;
        expect_next(mk(8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 8'd10));
        tick("idle_after_stop");

        // A write while running is dropped.
        START     = 1'b1;
        LAST_ADDR = 4'd3;
        LOOP      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                LOAD_EN    = 1'b1;
                LOAD_ADDR  = 4'd1;
                LOAD_INSTR = 8'hFF;
                LOAD_DATA  = 8'hFF;
            end
            expect_next(mk(ref_instr[i], ref_data[i], 4'(i), 1'b1, 1'b0, 8'(i + 1)));
            tick("run_wr_ignored");
            START   = 1'b0;
            LOAD_EN = 1'b0;
        end
        expect_next(mk(8'h00, 8'h00, 4'd3, 1'b0, 1'b1, 8'd4));
        tick("done_after_wr");
        run_prog(4'd3, 1'b0, 4, "rerun_word1_kept");
        expect_next(mk(8'h00, 8'h00, 4'd3, 1'b0, 1'b1, 8'd4));
        tick("done_rerun");

        // A write on the START edge: the old word 0 is presented, and the new one is committed.
        LOAD_EN    = 1'b1;
        LOAD_ADDR  = 4'd0;
        LOAD_INSTR = 8'h55;
        LOAD_DATA  = 8'h01;
        run_prog(4'd0, 1'b0, 1, "start_rbw_old");
        ref_instr[0] = 8'h55;
        ref_data[0]  = 8'h01;
        expect_next(mk(8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'd1));
        tick("done_rbw");
        run_prog(4'd0, 1'b0, 1, "start_rbw_new");
        expect_next(mk(8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'd1));
        tick("done_rbw_new");

        // START and STOP together: DONE goes to IDLE, and IDLE stays IDLE.
        START = 1'b1;
        STOP  = 1'b1;
        expect_next(mk(8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 8'd1));
        tick("startstop_done");
        expect_next(mk(8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 8'd1));
        tick("startstop_idle");
        START = 1'b0;
        STOP  = 1'b0;

        // Reset in mid-run at PC=2 clears the outputs and the memory.
        run_prog(4'd3, 1'b0, 3, "run_pre_reset");
        RESET = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ref_instr[i] = 8'h00;
            ref_data[i]  = 8'h00;
        end
        expect_next(mk(8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 8'd0));
        tick("reset_midrun");
        RESET = 1'b0;

        // Single-word program from cleared memory.
        run_prog(4'd0, 1'b0, 1, "single_cleared");
        expect_next(mk(8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 8'd1));
        tick("done_single");

        // 300-word loop on one word: ISSUED wraps to 44.
        run_prog(4'd0, 1'b1, 300, "loop_wrap");
        STOP = 1'b1;
        expect_next(mk(8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 8'd44));
        tick("stop_wrap");
        STOP = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
